// File: rtl/step_sequencer.sv
// step_sequencer: advances a step pointer through a writable pattern memory on rising edges of iTICK.
// Define SEQ_GATE_HOLD_EN so that oGATE holds for the whole step (legato) instead of pulsing for one cycle.
module step_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int STEP_W    = 4,
    parameter int NOTE_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              iRST_N,
    input  logic              iTICK,
    input  logic              iRUN,
    input  logic              iRESTART,
    input  logic [STEP_W-1:0] iLAST,
    input  logic              iWR_EN,
    input  logic [STEP_W-1:0] iWR_ADDR,
    input  logic [NOTE_W:0]   iWR_DATA,
    output logic [STEP_W-1:0] oSTEP,
    output logic [NOTE_W-1:0] oNOTE,
    output logic              oGATE,
    output logic              oSTROBE,
    output logic              oRUNNING
);
    typedef enum logic [1:0] {STOP, ARM, RUN} state_t;
    state_t            state;
    logic              tick_d, restart_pend, rise, adv;
    logic [NOTE_W:0]   mem [NUM_STEPS];
    logic [STEP_W-1:0] next_step;
    logic [NOTE_W:0]   next_data;

    assign rise = iTICK & ~tick_d;

    // A write landing on the step being entered is forwarded so the new data plays immediately.
    always_comb begin
        adv       = rise && iRUN && state != STOP;
        next_step = (state == RUN && !(restart_pend || iRESTART || oSTEP >= iLAST)) ? oSTEP + 1'b1 : '0;
        next_data = (iWR_EN && iWR_ADDR == next_step) ? iWR_DATA : mem[next_step];
    end

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= STOP;
            tick_d       <= 1'b1;
            restart_pend <= 1'b0;
            oSTEP        <= '0;
            oNOTE        <= '0;
            oGATE        <= 1'b0;
            oSTROBE      <= 1'b0;
            oRUNNING     <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
        end else begin
            tick_d       <= iTICK;
            oSTROBE      <= adv;
            oRUNNING     <= iRUN;
            restart_pend <= state == RUN && iRUN && !adv && (restart_pend || iRESTART);
            state        <= !iRUN ? STOP : state == STOP ? ARM : adv ? RUN : state;
            if (iWR_EN) mem[iWR_ADDR] <= iWR_DATA;
            if (adv) begin
                oSTEP <= next_step;
                oNOTE <= next_data[NOTE_W-1:0];
            end
`ifdef SEQ_GATE_HOLD_EN
            oGATE <= (!iRUN || state == STOP) ? 1'b0 : adv ? next_data[NOTE_W] : oGATE;
`else
            oGATE <= adv & next_data[NOTE_W];
`endif
        end
    end
endmodule
